// File: rtl/qa_driver_csr_wr_bank_pkg.sv
// qa_driver_csr_types: shared decode types, CTRL bit positions and the CSR bank address decoder.
package qa_driver_csr_types;
  typedef enum logic [2:0] {K_NONE, K_LO, K_HI, K_DOORBELL, K_CTRL} t_csr_kind;
  typedef struct packed {
    t_csr_kind kind;
    logic [4:0] idx;
  } t_csr_bank_off;
  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_CLR_VALID = 1;
  localparam int CTRL_FLUSH = 2;
  // off is already reduced modulo 2^ADDR_W and zero-extended by the caller
  function automatic t_csr_bank_off csr_bank_decode(input logic [31:0] off, input int unsigned num_regs);
    t_csr_bank_off r;
    r.idx = off[5:1];
    r.kind = off < 2 * num_regs ? (off[0] ? K_HI : K_LO) :
             off == 2 * num_regs ? K_DOORBELL :
             off == 2 * num_regs + 1 ? K_CTRL : K_NONE;
    return r;
  endfunction
endpackage

// File: rtl/qa_driver_csr_wr_bank_if.sv
// qa_driver_csr_wr_bank_if: host CSR write bus (csr_wr_valid/addr/data); master drives, slave snoops.
interface qa_driver_csr_wr_bank_if #(parameter int ADDR_W = 14) ();
  logic csr_wr_valid;
  logic [ADDR_W-1:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  modport master(output csr_wr_valid, csr_wr_addr, csr_wr_data);
  modport slave(input csr_wr_valid, csr_wr_addr, csr_wr_data);
endinterface

// File: rtl/qa_driver_csr_cmd_fifo.sv
// qa_driver_csr_cmd_fifo: first-word-fall-through FIFO with flush and sticky overflow.
// Ports: clk, reset_n (sync active-low), enq/enq_data, deq, flush, clr_ovf in;
//        valid/data (head), count, overflow out.
module qa_driver_csr_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic deq,
  input  logic flush,
  input  logic clr_ovf,
  output logic valid,
  output logic [WIDTH-1:0] data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_enq, do_deq;
  assign do_deq = deq && count != '0;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign do_enq = enq && (count != CW'(DEPTH) || do_deq);
  assign valid = count != '0;
  assign data = mem[rp];
  always_ff @(posedge clk)
    if (do_enq) mem[wp] <= enq_data;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_enq) wp <= wp + PW'(1);
      if (do_deq) rp <= rp + PW'(1);
      count <= count + CW'(do_enq) - CW'(do_deq);
      if (flush) begin
        wp <= '0;
        rp <= '0;
        count <= '0;
      end
      overflow <= (enq && !do_enq) || (overflow && !clr_ovf);
    end
  end
endmodule

// File: rtl/qa_driver_csr_wr_bank.sv
// qa_driver_csr_wr_bank: CSR write decoder assembling 64-bit registers from LO/HI halves plus a doorbell FIFO.
// Ports: clk, reset_n (sync active-low), csr (CSR write bus, slave), reg_value/reg_valid/reg_update out,
//        cmd_valid/cmd_data/cmd_count/cmd_overflow out, cmd_deq in.
module qa_driver_csr_wr_bank
  import qa_driver_csr_types::*;
#(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h0100,
  parameter int ATOMIC = 1,
  parameter int CMD_DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  qa_driver_csr_wr_bank_if.slave csr,
  output logic [NUM_REGS*64-1:0] reg_value,
  output logic [NUM_REGS-1:0] reg_valid,
  output logic [NUM_REGS-1:0] reg_update,
  output logic cmd_valid,
  output logic [31:0] cmd_data,
  input  logic cmd_deq,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
  output logic cmd_overflow
);
  logic [ADDR_W-1:0] off;
  t_csr_bank_off dec;
  logic wr_lo, wr_hi, wr_db, wr_ctrl;
  // subtraction wraps modulo 2^ADDR_W so addresses below BASE_ADDR land far out of range
  assign off = csr.csr_wr_addr - BASE_ADDR;
  assign dec = csr_bank_decode(32'(off), NUM_REGS);
  assign wr_lo = csr.csr_wr_valid && dec.kind == K_LO;
  assign wr_hi = csr.csr_wr_valid && dec.kind == K_HI;
  assign wr_db = csr.csr_wr_valid && dec.kind == K_DOORBELL;
  assign wr_ctrl = csr.csr_wr_valid && dec.kind == K_CTRL;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [63:0] v;
    logic [31:0] sh;
    logic ok, up;
    logic hit;
    assign hit = dec.idx == 5'(g);
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v <= '0;
        sh <= '0;
        ok <= 1'b0;
        up <= 1'b0;
      end else begin
        up <= 1'b0;
        if (wr_lo && hit) begin
          if (ATOMIC != 0) sh <= csr.csr_wr_data;
          else begin
            v[31:0] <= csr.csr_wr_data;
            up <= 1'b1;
          end
        end
        if (wr_hi && hit) begin
          v[63:32] <= csr.csr_wr_data;
          if (ATOMIC != 0) v[31:0] <= sh;
          ok <= 1'b1;
          up <= 1'b1;
        end else if (wr_ctrl && csr.csr_wr_data[CTRL_CLR_VALID]) ok <= 1'b0;
      end
    end
    assign reg_value[64*g +: 64] = v;
    assign reg_valid[g] = ok;
    assign reg_update[g] = up;
  end
  qa_driver_csr_cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .enq(wr_db),
    .enq_data(csr.csr_wr_data),
    .deq(cmd_deq),
    .flush(wr_ctrl && csr.csr_wr_data[CTRL_FLUSH]),
    .clr_ovf(wr_ctrl && csr.csr_wr_data[CTRL_CLR_OVF]),
    .valid(cmd_valid),
    .data(cmd_data),
    .count(cmd_count),
    .overflow(cmd_overflow)
  );
endmodule

// File: tb/tb_qa_driver_csr_wr_bank.sv
// tb_qa_driver_csr_wr_bank: directed self-checking bench for an ATOMIC=1 and an ATOMIC=0 instance.
module tb_qa_driver_csr_wr_bank;
  logic clk = 0;
  logic reset_n = 0;
  always #5 clk = ~clk;
  qa_driver_csr_wr_bank_if #(.ADDR_W(14)) bus ();
  qa_driver_csr_wr_bank_if #(.ADDR_W(14)) bus_l ();
  logic [255:0] reg_value, reg_value_l;
  logic [3:0] reg_valid, reg_valid_l, reg_update, reg_update_l;
  logic cmd_valid, cmd_valid_l, cmd_overflow, cmd_overflow_l;
  logic [31:0] cmd_data, cmd_data_l;
  logic [3:0] cmd_count, cmd_count_l;
  logic cmd_deq = 0;
  logic cmd_deq_l = 0;
  int checks = 0;
  int errors = 0;
  qa_driver_csr_wr_bank #(.ATOMIC(1)) dut (
    .clk(clk), .reset_n(reset_n), .csr(bus.slave),
    .reg_value(reg_value), .reg_valid(reg_valid), .reg_update(reg_update),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_deq(cmd_deq),
    .cmd_count(cmd_count), .cmd_overflow(cmd_overflow)
  );
  qa_driver_csr_wr_bank #(.ATOMIC(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .csr(bus_l.slave),
    .reg_value(reg_value_l), .reg_valid(reg_valid_l), .reg_update(reg_update_l),
    .cmd_valid(cmd_valid_l), .cmd_data(cmd_data_l), .cmd_deq(cmd_deq_l),
    .cmd_count(cmd_count_l), .cmd_overflow(cmd_overflow_l)
  );
  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    bus.csr_wr_valid = 1;
    bus.csr_wr_addr = a;
    bus.csr_wr_data = d;
    tick();
    bus.csr_wr_valid = 0;
  endtask
  task automatic wr_l(input logic [13:0] a, input logic [31:0] d);
    bus_l.csr_wr_valid = 1;
    bus_l.csr_wr_addr = a;
    bus_l.csr_wr_data = d;
    tick();
    bus_l.csr_wr_valid = 0;
  endtask
  task automatic test_reset();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    checks++; if (reg_value !== '0) begin errors++; $display("FAIL reset_value got %h want 0", reg_value); end
    checks++; if (reg_valid !== 4'b0 || reg_update !== 4'b0) begin errors++; $display("FAIL reset_flags got valid %b upd %b want 0 0", reg_valid, reg_update); end
    checks++; if (cmd_count !== 4'd0 || cmd_valid !== 1'b0 || cmd_overflow !== 1'b0) begin errors++; $display("FAIL reset_fifo got cnt %0d v %b ovf %b want 0 0 0", cmd_count, cmd_valid, cmd_overflow); end
  endtask
  task automatic test_atomic();
    wr(14'h0100, 32'hDEADBEEF);
    checks++; if (reg_update !== 4'b0 || reg_value[63:0] !== 64'h0) begin errors++; $display("FAIL lo_only got upd %b val %h want 0 0", reg_update, reg_value[63:0]); end
    wr(14'h0101, 32'h12345678);
    checks++; if (reg_value[63:0] !== 64'h12345678DEADBEEF) begin errors++; $display("FAIL commit0 got %h want 12345678deadbeef", reg_value[63:0]); end
    checks++; if (reg_valid !== 4'b0001 || reg_update !== 4'b0001) begin errors++; $display("FAIL commit0_flags got valid %b upd %b want 0001 0001", reg_valid, reg_update); end
    tick();
    checks++; if (reg_update !== 4'b0) begin errors++; $display("FAIL pulse_width got %b want 0000", reg_update); end
  endtask
  task automatic test_hi_no_lo();
    wr(14'h0103, 32'h1);
    checks++; if (reg_value[127:64] !== 64'h0000000100000000 || reg_update !== 4'b0010) begin errors++; $display("FAIL hi_no_lo got %h upd %b want 0000000100000000 0010", reg_value[127:64], reg_update); end
    wr(14'h0102, 32'h5);
    tick();
    checks++; if (reg_value[127:64] !== 64'h0000000100000000 || reg_valid !== 4'b0011) begin errors++; $display("FAIL lo_alone got %h valid %b want 0000000100000000 0011", reg_value[127:64], reg_valid); end
  endtask
  task automatic test_back_to_back();
    wr(14'h0104, 32'hA);
    wr(14'h0105, 32'hB);
    checks++; if (reg_value[191:128] !== 64'h0000000B0000000A || reg_update !== 4'b0100) begin errors++; $display("FAIL b2b_commit got %h upd %b want 0000000b0000000a 0100", reg_value[191:128], reg_update); end
    wr(14'h0105, 32'hC);
    checks++; if (reg_value[191:128] !== 64'h0000000C0000000A || reg_update !== 4'b0100) begin errors++; $display("FAIL b2b_pulse got %h upd %b want 0000000c0000000a 0100", reg_value[191:128], reg_update); end
    tick();
  endtask
  task automatic test_live();
    wr_l(14'h0100, 32'hAA);
    checks++; if (reg_value_l[63:0] !== 64'hAA || reg_update_l !== 4'b0001 || reg_valid_l !== 4'b0) begin errors++; $display("FAIL live_lo got %h upd %b valid %b want aa 0001 0000", reg_value_l[63:0], reg_update_l, reg_valid_l); end
    wr_l(14'h0101, 32'hBB);
    checks++; if (reg_value_l[63:0] !== 64'h000000BB000000AA || reg_update_l !== 4'b0001 || reg_valid_l !== 4'b0001) begin errors++; $display("FAIL live_hi got %h upd %b valid %b want 000000bb000000aa 0001 0001", reg_value_l[63:0], reg_update_l, reg_valid_l); end
  endtask
  task automatic test_doorbell();
    for (int i = 1; i <= 9; i++) begin
      wr(14'h0108, 32'(i));
      if (i == 1) begin
        checks++; if (cmd_valid !== 1'b1 || cmd_data !== 32'd1 || cmd_count !== 4'd1) begin errors++; $display("FAIL db_first got v %b d %0d cnt %0d want 1 1 1", cmd_valid, cmd_data, cmd_count); end
      end
    end
    checks++; if (cmd_count !== 4'd8 || cmd_overflow !== 1'b1 || cmd_data !== 32'd1) begin errors++; $display("FAIL db_full got cnt %0d ovf %b head %0d want 8 1 1", cmd_count, cmd_overflow, cmd_data); end
    cmd_deq = 1;
    wr(14'h0108, 32'd10);
    cmd_deq = 0;
    checks++; if (cmd_count !== 4'd8 || cmd_data !== 32'd2) begin errors++; $display("FAIL db_full_enq_deq got cnt %0d head %0d want 8 2", cmd_count, cmd_data); end
    for (int i = 2; i <= 8; i++) begin
      checks++; if (cmd_data !== 32'(i)) begin errors++; $display("FAIL db_order got %0d want %0d", cmd_data, i); end
      cmd_deq = 1;
      tick();
      cmd_deq = 0;
    end
    checks++; if (cmd_data !== 32'd10 || cmd_count !== 4'd1) begin errors++; $display("FAIL db_tenth got %0d cnt %0d want 10 1", cmd_data, cmd_count); end
    cmd_deq = 1;
    tick();
    tick();
    cmd_deq = 0;
    checks++; if (cmd_count !== 4'd0 || cmd_valid !== 1'b0 || cmd_overflow !== 1'b1) begin errors++; $display("FAIL db_empty got cnt %0d v %b ovf %b want 0 0 1", cmd_count, cmd_valid, cmd_overflow); end
    cmd_deq = 1;
    wr(14'h0108, 32'h55);
    cmd_deq = 0;
    checks++; if (cmd_count !== 4'd1 || cmd_data !== 32'h55) begin errors++; $display("FAIL db_empty_enq_deq got cnt %0d d %h want 1 55", cmd_count, cmd_data); end
  endtask
  task automatic test_ctrl();
    logic [255:0] exp;
    exp = {64'h0, 64'h0000000C0000000A, 64'h0000000100000000, 64'h12345678DEADBEEF};
    wr(14'h0109, 32'h7);
    checks++; if (cmd_overflow !== 1'b0 || reg_valid !== 4'b0 || cmd_count !== 4'd0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL ctrl_clear got ovf %b valid %b cnt %0d v %b want 0 0000 0 0", cmd_overflow, reg_valid, cmd_count, cmd_valid); end
    checks++; if (reg_value !== exp || reg_update !== 4'b0) begin errors++; $display("FAIL ctrl_keep got %h upd %b want %h 0000", reg_value, reg_update, exp); end
    wr(14'h00FF, 32'hFFFFFFFF);
    wr(14'h010A, 32'hFFFFFFFF);
    checks++; if (reg_value !== exp || reg_valid !== 4'b0 || reg_update !== 4'b0 || cmd_count !== 4'd0 || cmd_overflow !== 1'b0) begin errors++; $display("FAIL ignored_addr got %h valid %b upd %b cnt %0d ovf %b want %h 0 0 0 0", reg_value, reg_valid, reg_update, cmd_count, cmd_overflow, exp); end
  endtask
  task automatic test_reset_mid();
    wr(14'h0104, 32'h77);
    reset_n = 0;
    tick();
    reset_n = 1;
    checks++; if (reg_value !== '0 || reg_update !== 4'b0) begin errors++; $display("FAIL mid_reset got %h upd %b want 0 0000", reg_value, reg_update); end
    wr(14'h0105, 32'h9);
    checks++; if (reg_value[191:128] !== 64'h0000000900000000 || reg_valid !== 4'b0100) begin errors++; $display("FAIL mid_reset_hi got %h valid %b want 0000000900000000 0100", reg_value[191:128], reg_valid); end
  endtask
  initial begin
    bus.csr_wr_valid = 0;
    bus.csr_wr_addr = '0;
    bus.csr_wr_data = '0;
    bus_l.csr_wr_valid = 0;
    bus_l.csr_wr_addr = '0;
    bus_l.csr_wr_data = '0;
    #1;
    test_reset();
    test_atomic();
    test_hi_no_lo();
    test_back_to_back();
    test_live();
    test_doorbell();
    test_ctrl();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
